// File: rtl/uart_pkg.sv
// uart_pkg: shared UART TX state type, line constants and baud divisor helper
package uart_pkg;
    typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, PARITY, STOP} tx_state_t;
    localparam int   DATA_BITS = 8;
    localparam logic LINE_IDLE = 1'b1;
    function automatic int bit_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction
endpackage

// File: rtl/uart_tx_drain_if.sv
// uart_tx_drain_if: standard-read FIFO read port (rd_en / 1-cycle dout / empty)
interface uart_tx_drain_if;
    logic       rd_en;
    logic [7:0] dout;
    logic       empty;
    modport master (output rd_en, input dout, input empty);
    modport slave  (input rd_en, output dout, output empty);
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter 0..BIT_DIV-1 with sync clear, tick on last count
module uart_baud_gen #(
    parameter int BIT_DIV = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic bit_tick,
    output logic pre_tick
);
    localparam int W = $clog2(BIT_DIV);
    logic [W-1:0] cnt;
    assign bit_tick = cnt == W'(BIT_DIV - 1);
    assign pre_tick = cnt == W'(BIT_DIV - 2);
    // free-running bit period, restarted by clr and wrapped on the tick
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else        cnt <= (clr || bit_tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_tx_drain.sv
// uart_tx_drain: pops bytes from a standard-read FIFO and sends them as 8N1 on txd_o
// Optional even-parity bit (8E1) when UART_TX_PARITY_EN is defined.
module uart_tx_drain import uart_pkg::*; #(
    parameter int BAUD_RATE  = 9_600,
    parameter int CLOCK_RATE = 40_000_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tx_enable,
    uart_tx_drain_if.master         fifo,
    output logic                    txd_o,
    output logic                    tx_busy,
    output logic                    tx_done
);
    localparam int BIT_DIV = bit_div(CLOCK_RATE, BAUD_RATE);
    tx_state_t  state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       txd_d, rd_en_d, done_d;
    logic       clr, bit_tick, pre_tick, last_txd;
    tx_state_t  after_data;

    // bit timing only runs once the byte is loaded; before that it is held at zero
    assign clr = state_q inside {IDLE, POP, LOAD};

    uart_baud_gen #(.BIT_DIV(BIT_DIV)) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .bit_tick (bit_tick),
        .pre_tick (pre_tick)
    );

`ifdef UART_TX_PARITY_EN
    logic par_q;
    // even parity of the byte captured alongside the shift register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)               par_q <= 1'b0;
        else if (state_q == LOAD) par_q <= ^fifo.dout;
    assign last_txd   = par_q;
    assign after_data = PARITY;
`else
    assign last_txd   = LINE_IDLE;
    assign after_data = STOP;
`endif

    // next state plus next values of the registered outputs
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        txd_d     = txd_o;
        rd_en_d   = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            IDLE: if (tx_enable && !fifo.empty) begin
                state_d = POP;
                rd_en_d = 1'b1;
            end
            POP:  state_d = LOAD;
            LOAD: begin
                shift_d   = fifo.dout;
                bit_cnt_d = '0;
                txd_d     = 1'b0;
                state_d   = START;
            end
            START: if (bit_tick) begin
                txd_d   = shift_q[0];
                state_d = DATA;
            end
            DATA: if (bit_tick) begin
                if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
                    txd_d   = last_txd;
                    state_d = after_data;
                end else begin
                    shift_d   = shift_q >> 1;
                    txd_d     = shift_q[1];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_tick) begin
                txd_d   = LINE_IDLE;
                state_d = STOP;
            end
`endif
            STOP: begin
                done_d  = pre_tick;
                state_d = bit_tick ? IDLE : STOP;
            end
            default: begin
                txd_d   = LINE_IDLE;
                state_d = IDLE;
            end
        endcase
    end

    // state, datapath and all outputs registered; reset forces the line idle at once
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            txd_o      <= LINE_IDLE;
            fifo.rd_en <= 1'b0;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            txd_o      <= txd_d;
            fifo.rd_en <= rd_en_d;
            tx_busy    <= state_d != IDLE;
            tx_done    <= done_d;
        end
endmodule

// File: tb/tb_uart_tx_drain.sv
// tb_uart_tx_drain: directed bench for uart_tx_drain at BIT_DIV=16 with a 1-cycle-latency FIFO model
module tb_uart_tx_drain;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tx_enable = 1'b0;
    logic txd_o, tx_busy, tx_done;
    logic [7:0] mem [16];
    int pushed = 0, popped = 0, rd_cnt = 0, underflow = 0;
    int tests = 0, failed = 0;
    int bad, base;

    uart_tx_drain_if f();

    uart_tx_drain #(.BAUD_RATE(100_000), .CLOCK_RATE(1_600_000)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tx_enable (tx_enable),
        .fifo      (f),
        .txd_o     (txd_o),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done)
    );

    always #5 clk = ~clk;

    assign f.empty = (pushed == popped);

    always @(posedge clk)
        if (f.rd_en) begin
            rd_cnt <= rd_cnt + 1;
            if (pushed == popped) underflow <= underflow + 1;
            else begin
                f.dout <= mem[popped[3:0]];
                popped <= popped + 1;
            end
        end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[pushed[3:0]] = b;
        pushed++;
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int j);
        return j == 0 ? 1'b0 : j <= 8 ? b[j-1] : (j == 9 && NB == 11) ? ^b : 1'b1;
    endfunction

    // called at the negedge of the first start-bit cycle; ends in the first idle cycle after stop
    task automatic frame(input logic [7:0] b, input string tag, input int drop);
        for (int c = 1; c <= NB*16 + 1; c++) begin
            if (c > 1) @(negedge clk);
            if (c == drop) tx_enable = 1'b0;
            if (c % 16 == 8) chk($sformatf("%s_bit%0d", tag, c/16), 32'(txd_o), 32'(exp_bit(b, c/16)));
            if (c == NB*16 - 1) chk({tag, "_done_early"}, 32'(tx_done), 0);
            if (c == NB*16) begin
                chk({tag, "_done"}, 32'(tx_done), 1);
                chk({tag, "_busy_last"}, 32'(tx_busy), 1);
            end
            if (c == NB*16 + 1) begin
                chk({tag, "_done_after"}, 32'(tx_done), 0);
                chk({tag, "_busy_after"}, 32'(tx_busy), 0);
                chk({tag, "_idle_high"}, 32'(txd_o), 1);
            end
        end
    endtask

    // called at a negedge inside the IDLE cycle that pops
    task automatic pop_frame(input logic [7:0] b, input string tag, input int drop);
        @(negedge clk);
        chk({tag, "_rd_en"}, 32'(f.rd_en), 1);
        chk({tag, "_busy_pop"}, 32'(tx_busy), 1);
        @(negedge clk);
        chk({tag, "_rd_en_once"}, 32'(f.rd_en), 0);
        chk({tag, "_gap_high"}, 32'(txd_o), 1);
        @(negedge clk);
        chk({tag, "_start_edge"}, 32'(txd_o), 0);
        frame(b, tag, drop);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_txd", 32'(txd_o), 1);
        chk("rst_busy", 32'(tx_busy), 0);
        chk("rst_done", 32'(tx_done), 0);
        chk("rst_rd_en", 32'(f.rd_en), 0);
        rst_n = 1'b1;
        tx_enable = 1'b1;

        bad = 0;
        repeat (500) begin
            @(negedge clk);
            if (f.rd_en !== 1'b0 || txd_o !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        chk("empty_idle_violations", 32'(bad), 0);

        base = rd_cnt;
        push(8'hA5);
        pop_frame(8'hA5, "a5", 0);
        chk("a5_pops", 32'(rd_cnt - base), 1);

        base = rd_cnt;
        push(8'h00);
        push(8'hFF);
        pop_frame(8'h00, "b2b_00", 0);
        pop_frame(8'hFF, "b2b_ff", 0);
        repeat (20) @(negedge clk);
        chk("b2b_pops", 32'(rd_cnt - base), 2);
        chk("b2b_fifo_empty", 32'(f.empty), 1);
        chk("b2b_underflow", 32'(underflow), 0);

        push(8'h3C);
        push(8'h55);
        pop_frame(8'h3C, "en_3c", 70);
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (f.rd_en !== 1'b0 || txd_o !== 1'b1) bad++;
        end
        chk("en_hold_violations", 32'(bad), 0);
        chk("en_pending", 32'(pushed - popped), 1);
        tx_enable = 1'b1;
        pop_frame(8'h55, "en_55", 0);

        push(8'h81);
        push(8'h7E);
        @(negedge clk);
        chk("rst_81_rd_en", 32'(f.rd_en), 1);
        repeat (2) @(negedge clk);
        chk("rst_81_start", 32'(txd_o), 0);
        repeat (42) @(negedge clk);
        chk("rst_81_bit1_low", 32'(txd_o), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_txd", 32'(txd_o), 1);
        chk("rst_async_busy", 32'(tx_busy), 0);
        chk("rst_async_rd_en", 32'(f.rd_en), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pop_frame(8'h7E, "rst_7e", 0);

`ifdef UART_TX_PARITY_EN
        push(8'h07);
        push(8'h03);
        pop_frame(8'h07, "par_07", 0);
        pop_frame(8'h03, "par_03", 0);
`endif

        repeat (20) @(negedge clk);
        chk("final_fifo_empty", 32'(f.empty), 1);
        chk("final_underflow", 32'(underflow), 0);
        chk("final_txd_idle", 32'(txd_o), 1);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
